// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared definitions for the data-memory arbiter.
//   - access size encodings (SZ_BYTE/SZ_HALF/SZ_WORD; 3 is reserved and
//     behaves as a word)
//   - controller state enum
//   - requester port indices
//   - misalignment helper
// Sub-word support is selected by DMEM_ARB_SUBWORD_EN in the users of this
// package; the helper itself is size-generic.
package dmem_arb_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   localparam int unsigned PORT_CPU = 0;
   localparam int unsigned PORT_DMA = 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WRITE  = 2'd2,
      RESP   = 2'd3
   } state_t;

   // Bytes are always aligned; halves need addr[0]=0; words (and the
   // reserved size) need addr[1:0]=0.
   function automatic logic is_misaligned(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return addr_lo[0];
         default: return (addr_lo != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: request/response bundle between the two requesters and
// the data-memory arbiter. Vectors are per port, port 1 in the upper half.
//   req_valid/req_ready  per-port handshake (ready is one-hot or zero)
//   req_we               1 = store
//   req_addr             byte address, 2 x ADDR_W
//   req_wdata            right-aligned store data, 2 x DATA_W
//   req_size             2 x 2: 0 byte, 1 half, 2 word, 3 word
//   req_unsigned         1 = zero-extend loads
//   resp_valid           one-cycle strobe to the owning port
//   resp_rdata           shared load result (0 for stores / errors)
//   resp_err             misalignment flag, qualified by resp_valid
// Modports: master = requester side, slave = arbiter side.
interface dmem_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic [1:0]          req_valid;
   logic [1:0]          req_ready;
   logic [1:0]          req_we;
   logic [2*ADDR_W-1:0] req_addr;
   logic [2*DATA_W-1:0] req_wdata;
   logic [3:0]          req_size;
   logic [1:0]          req_unsigned;
   logic [1:0]          resp_valid;
   logic [DATA_W-1:0]   resp_rdata;
   logic                resp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational lane steering for the data-memory arbiter.
//   addr_lo     byte offset within the word
//   size        SZ_BYTE / SZ_HALF / other = word
//   is_unsigned 1 = zero-extend, 0 = sign-extend loads
//   rdata       word read from memory
//   wdata_lo    low 16 bits of the store data
//   load_data   extracted and extended load value
//   merge_data  rdata with the addressed lane(s) replaced by store data
// Only used when DMEM_ARB_SUBWORD_EN is defined.
module dmem_lane_align
   import dmem_arb_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic [1:0]        addr_lo,
   input  logic [1:0]        size,
   input  logic              is_unsigned,
   input  logic [DATA_W-1:0] rdata,
   input  logic [15:0]       wdata_lo,
   output logic [DATA_W-1:0] load_data,
   output logic [DATA_W-1:0] merge_data
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      case (addr_lo)
         2'd0:    byte_v = rdata[7:0];
         2'd1:    byte_v = rdata[15:8];
         2'd2:    byte_v = rdata[23:16];
         default: byte_v = rdata[31:24];
      endcase
      // Halves are already known aligned here, so only addr[1] matters.
      half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      load_data  = rdata;
      merge_data = rdata;
      case (size)
         SZ_BYTE: begin
            load_data = is_unsigned ? {{(DATA_W-8){1'b0}}, byte_v}
                                    : {{(DATA_W-8){byte_v[7]}}, byte_v};
            merge_data[8*addr_lo +: 8] = wdata_lo[7:0];
         end
         SZ_HALF: begin
            load_data = is_unsigned ? {{(DATA_W-16){1'b0}}, half_v}
                                    : {{(DATA_W-16){half_v[15]}}, half_v};
            if (addr_lo[1]) merge_data[31:16] = wdata_lo;
            else            merge_data[15:0]  = wdata_lo;
         end
         default: begin
            load_data  = rdata;
            merge_data = rdata;
         end
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter and access sequencer in front of the
// word-wide data memory. Port 0 = CPU, port 1 = DMA/debug.
//   clk, rst    clock, synchronous active-high reset
//   bus         dmem_arbiter_if.slave request/response bundle
//   mem_addr    word-aligned memory address
//   mem_wdata   word to write
//   mem_read    memory read strobe
//   mem_write   memory write strobe
//   mem_rdata   combinational read data from memory
// Build option DMEM_ARB_SUBWORD_EN: when defined, byte/half loads and
// read-modify-write byte/half stores are supported; when undefined every
// access is a 32-bit word and size/unsigned are ignored.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   dmem_arbiter_if.slave     bus,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_t state, state_nxt;

   logic              last_grant;
   logic              grant;
   logic              any_valid;
   logic              handshake;

   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_we;
   logic [1:0]        sel_size;
   logic              sel_mis;

   logic              owner;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_we;
   logic              is_sub;
   logic [DATA_W-1:0] load_data;

`ifdef DMEM_ARB_SUBWORD_EN
   logic [1:0]        r_size;
   logic              r_uns;
   logic              sel_uns;
   logic [DATA_W-1:0] merge_data;
   logic [DATA_W-1:0] merged;
`else
   logic              unused_cfg;
`endif

   // With both valid, alternate away from last_grant; otherwise the single
   // valid port wins (value is irrelevant when nothing is valid).
   always_comb begin
      any_valid = |bus.req_valid;
      if (&bus.req_valid) grant = ~last_grant;
      else                grant = bus.req_valid[PORT_DMA];
   end

   always_comb begin
      sel_addr  = grant ? bus.req_addr[2*ADDR_W-1:ADDR_W]  : bus.req_addr[ADDR_W-1:0];
      sel_wdata = grant ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];
      sel_we    = bus.req_we[grant];
`ifdef DMEM_ARB_SUBWORD_EN
      sel_size  = grant ? bus.req_size[3:2] : bus.req_size[1:0];
      sel_uns   = bus.req_unsigned[grant];
`else
      sel_size  = SZ_WORD;
`endif
      sel_mis   = is_misaligned(sel_size, sel_addr[1:0]);
   end

   assign handshake = |(bus.req_valid & bus.req_ready);

`ifdef DMEM_ARB_SUBWORD_EN
   assign is_sub = r_we && ((r_size == SZ_BYTE) || (r_size == SZ_HALF));

   dmem_lane_align #(
      .DATA_W (DATA_W)
   ) u_lane_align (
      .addr_lo     (r_addr[1:0]),
      .size        (r_size),
      .is_unsigned (r_uns),
      .rdata       (mem_rdata),
      .wdata_lo    (r_wdata[15:0]),
      .load_data   (load_data),
      .merge_data  (merge_data)
   );

   assign mem_wdata = (state == WRITE) ? merged : r_wdata;
`else
   assign is_sub     = 1'b0;
   assign load_data  = mem_rdata;
   assign mem_wdata  = r_wdata;
   assign unused_cfg = ^{bus.req_size, bus.req_unsigned, r_addr[1:0]};
`endif

   assign mem_addr = {r_addr[ADDR_W-1:2], 2'b00};

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      bus.req_ready  = '0;
      bus.resp_valid = '0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      unique case (state)
         IDLE: begin
            if (any_valid) begin
               bus.req_ready[grant] = 1'b1;
               state_nxt = sel_mis ? RESP : ACCESS;
            end
         end
         ACCESS: begin
            if (!r_we) begin
               mem_read  = 1'b1;
               state_nxt = RESP;
            end else if (is_sub) begin
               mem_read  = 1'b1;
               state_nxt = WRITE;
            end else begin
               mem_write = 1'b1;
               state_nxt = RESP;
            end
         end
`ifdef DMEM_ARB_SUBWORD_EN
         WRITE: begin
            mem_write = 1'b1;
            state_nxt = RESP;
         end
`endif
         RESP: begin
            bus.resp_valid[owner] = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // Reset drops any in-flight access without a strobe or response.
      if (rst) begin
         bus.req_ready  = '0;
         bus.resp_valid = '0;
         mem_read       = 1'b0;
         mem_write      = 1'b0;
         state_nxt      = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant     <= 1'b1;
         owner          <= 1'b0;
         r_addr         <= '0;
         r_wdata        <= '0;
         r_we           <= 1'b0;
         bus.resp_rdata <= '0;
         bus.resp_err   <= 1'b0;
`ifdef DMEM_ARB_SUBWORD_EN
         r_size         <= SZ_WORD;
         r_uns          <= 1'b0;
         merged         <= '0;
`endif
      end else begin
         if (handshake) begin
            last_grant     <= grant;
            owner          <= grant;
            r_addr         <= sel_addr;
            r_wdata        <= sel_wdata;
            r_we           <= sel_we;
            bus.resp_rdata <= '0;
            bus.resp_err   <= sel_mis;
`ifdef DMEM_ARB_SUBWORD_EN
            r_size         <= sel_size;
            r_uns          <= sel_uns;
`endif
         end
         if ((state == ACCESS) && !r_we) bus.resp_rdata <= load_data;
`ifdef DMEM_ARB_SUBWORD_EN
         if ((state == ACCESS) && is_sub) merged <= merge_data;
`endif
      end
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester controller in front of the 256-word data memory. It arbitrates round-robin between the CPU load/store port (port 0) and a DMA/debug port (port 1), and sequences each access into memory read/write strobes. Byte and halfword stores are done as read-modify-write, because the memory writes whole words only. Loads are returned sign- or zero-extended through a registered response.

## Interface
Parameters:
- ADDR_W, 32, request address width.
- DATA_W, 32, data width; fixed at 32, other values unsupported.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-port request valid; bit 0 = CPU, bit 1 = DMA.
- req_ready  out  2  per-port accept; at most one bit high.
- req_we  in  2  per-port write enable (1 = store).
- req_addr  in  2×32  per-port byte address, packed with port 1 in the upper half.
- req_wdata  in  2×32  per-port store data, right-aligned.
- req_size  in  2×2  per-port size: 0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word).
- req_unsigned  in  2  per-port flag: 1 = zero-extend loads.
- resp_valid  out  2  one-cycle response strobe to the owning port.
- resp_rdata  out  32  load result, shared between ports; 0 for stores.
- resp_err  out  1  misaligned-access flag, qualified by resp_valid.
- mem_addr  out  32  {addr[31:2], 2'b00}.
- mem_wdata  out  32  word to write.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_rdata  in  32  combinational read data from the memory.

## Operation
- FSM states: IDLE, ACCESS, WRITE, RESP.
- IDLE:
  - req_ready is raised to the granted port.
  - On handshake, addr, wdata, size, we, unsigned and owner are registered, and the FSM goes to ACCESS.
- Arbitration:
  - last_grant resets to 1.
  - When both ports are valid, grant goes to the port that is not last_grant.
  - When one port is valid, grant goes to that port.
  - last_grant updates on every handshake.
- Misalignment:
  - A half with addr[0]=1, or a word with addr[1:0]≠0, is misaligned.
  - A misaligned request skips ACCESS and WRITE.
  - It goes IDLE→RESP with resp_err=1, no mem strobes and resp_rdata=0.
- ACCESS:
  - Load: mem_read=1. The byte or half is extracted by addr[1:0], extended per unsigned, registered into resp_rdata, then → RESP.
  - Word store: mem_write=1 with mem_wdata=wdata, then → RESP.
  - Sub-word store: mem_read=1. The target lane(s) of mem_rdata are replaced with wdata[7:0] or wdata[15:0], and the merged word is registered, then → WRITE.
- WRITE: mem_write=1 with the merged word, then → RESP.
- RESP: resp_valid[owner]=1 for one cycle, then → IDLE. No new grant is made in RESP.
- mem_read and mem_write are never high together. Both are 0 outside ACCESS and WRITE.

## Timing
- Reset values: state=IDLE, req_ready=0 during the rst cycle, resp_valid=0, resp_rdata=0, resp_err=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, last_grant=1.
- Strobes are gated by rst. A reset during ACCESS or WRITE drops the transaction with no write issued in the rst cycle and no response. A pending RMW is lost.
- Latency, with the handshake at edge T:
  - Load or word store: ACCESS in cycle T+1, resp_valid in T+2.
  - Sub-word store: ACCESS T+1, WRITE T+2, resp_valid T+3.
  - Misaligned: resp_valid in T+1.
- Throughput: one transaction per 3 cycles (4 for sub-word stores). The next grant is possible in the cycle after RESP.
- Requesters hold req_* stable while valid and not ready. req_ready is combinational from req_valid and state.

## Configuration
- DMEM_ARB_SUBWORD_EN:
  - Defined: byte and half loads and stores, the WRITE state and RMW are supported as above.
  - Undefined: req_size and req_unsigned are ignored and every access is a 32-bit word. The WRITE state and merge logic are removed. Misalignment is checked on addr[1:0]≠0 only.

## Structure
- Shared package dmem_arb_pkg:
  - size encodings SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2;
  - state enum IDLE/ACCESS/WRITE/RESP;
  - port indices PORT_CPU=0, PORT_DMA=1.
- One sub-module, dmem_lane_align. It is purely combinational: load extract/extend plus store merge, driven by addr[1:0], size and unsigned.

## Test plan
- Port 0 word store to 0x10 with data 0xDEADBEEF, then a word load from 0x10 → mem_write in T+1 with mem_addr=0x10; the load returns resp_rdata=0xDEADBEEF, resp_err=0 in T+2.
- Memory word 0x11223344 at 0x20; signed byte load from 0x23 → 0x00000011. Store 0xAB as a byte to 0x21 → WRITE with mem_wdata=0x1122AB44, resp_valid in T+3.
- Signed half load of 0x8001 at 0x22 → 0xFFFF8001; the same load with unsigned=1 → 0x00008001.
- Both ports valid continuously after reset → grants alternate 0,1,0,1. resp_valid bit matches the owner each time, and no grant occurs while not in IDLE.
- Word load from 0x0000_0006 → resp_err=1 in T+1, no mem_read or mem_write pulse, resp_rdata=0.
- Sub-word store with rst asserted in the WRITE cycle → mem_write=0 that cycle, no resp_valid, state=IDLE, and both req_ready bits evaluated fresh in the next cycle.
